keypad_scanner: RTL and testbench

//  Scans a 4x4 key matrix and turns it into debounced, hex-coded key events for the processor.

---
 rtl/keypad_scanner.sv | 170 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: column drive, row synchronizer,
// per-scan lowest-code hit, debounce FSM and ack handshake.
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic       keyAck,
  output logic [3:0] colSelect,
  output logic [3:0] keyCode,
  output logic       keyValid,
  output logic       keyHeld,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1) + 1;

  typedef enum logic [1:0] {
    IDLE, CAND, PRESSED, REL
  } state_t;

  state_t        state;
  logic          scanning;
  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic [3:0]    rs1;
  logic [3:0]    rs;
  logic          acc_hit;
  logic [3:0]    acc_code;
  logic [3:0]    cand;
  logic [CW-1:0] cnt;

  logic          last;
  logic          scan_end;
  logic          col_hit;
  logic [3:0]    col_code;
  logic          sc_hit;
  logic [3:0]    sc_code;
  logic          same;
  logic          cnt_done;
  logic          accept;

  assign colSelect = scanning ? ~(4'b0001 << col) : 4'hF;

  assign last     = scanning && (dwell == DW'(SCAN_DIV - 1));
  assign scan_end = last && (col == 2'd3);

  // Lowest row wins within a column.
  always_comb begin
    col_hit  = 1'b0;
    col_code = 4'h0;
    for (int r = 3; r >= 0; r--) begin
      if (!rs[r]) begin
        col_hit  = 1'b1;
        col_code = {2'(r), col};
      end
    end
  end

  // Codes are not ordered by column, so compare explicitly.
  always_comb begin
    sc_hit  = acc_hit | col_hit;
    sc_code = col_code;
    if (acc_hit && (!col_hit || acc_code < col_code))
      sc_code = acc_code;
  end

  assign same     = sc_hit && (sc_code == cand);
  assign cnt_done = (int'(cnt) + 1) >= DEBOUNCE;
  assign accept   = scan_end && sc_hit &&
                    ((state == IDLE && DEBOUNCE == 1) ||
                     (state == CAND && same && cnt_done));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      scanning <= 1'b0;
      col      <= 2'd0;
      dwell    <= '0;
      rs1      <= 4'hF;
      rs       <= 4'hF;
      acc_hit  <= 1'b0;
      acc_code <= 4'h0;
      cand     <= 4'h0;
      cnt      <= '0;
      keyCode  <= 4'h0;
      keyValid <= 1'b0;
      keyHeld  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rs1      <= row;
      rs       <= rs1;
      scanning <= 1'b1;

      if (scanning) begin
        if (last) begin
          dwell <= '0;
          col   <= col + 2'd1;
        end else begin
          dwell <= dwell + DW'(1);
        end
      end

      if (last) begin
        acc_hit  <= scan_end ? 1'b0 : sc_hit;
        acc_code <= sc_code;
      end

      if (accept) begin
        keyCode  <= sc_code;
        keyValid <= 1'b1;
        keyHeld  <= 1'b1;
        if (keyValid && !keyAck)
          overrun <= 1'b1;
      end else if (keyAck) begin
        keyValid <= 1'b0;
      end

      if (scan_end) begin
        case (state)
          IDLE: begin
            if (sc_hit) begin
              cand  <= sc_code;
              cnt   <= CW'(1);
              state <= (DEBOUNCE == 1) ? PRESSED : CAND;
            end
          end
          CAND: begin
            if (!sc_hit) begin
              state <= IDLE;
            end else if (same) begin
              cnt <= cnt + CW'(1);
              if (cnt_done)
                state <= PRESSED;
            end else begin
              cand <= sc_code;
              cnt  <= CW'(1);
            end
          end
          PRESSED: begin
            if (!same) begin
              cnt <= CW'(1);
              if (DEBOUNCE == 1) begin
                state   <= IDLE;
                keyHeld <= 1'b0;
              end else begin
                state <= REL;
              end
            end
          end
          REL: begin
            if (same) begin
              state <= PRESSED;
            end else if (cnt_done) begin
              state   <= IDLE;
              keyHeld <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational
// key-matrix model driven from a pressed-key mask.
module tb_keypad_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] row;
  logic       keyAck;
  logic [3:0] colSelect;
  logic [3:0] keyCode;
  logic       keyValid;
  logic       keyHeld;
  logic       overrun;

  logic [15:0] keys;
  int          total;
  int          fails;
  int          cyc;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE(3)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row      (row),
    .keyAck   (keyAck),
    .colSelect(colSelect),
    .keyCode  (keyCode),
    .keyValid (keyValid),
    .keyHeld  (keyHeld),
    .overrun  (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pressed key r*4+c pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !colSelect[c])
          row[r] = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      cyc++;
    end
    #1;
  endtask

  task automatic align();
    while (cyc % 16 != 0) tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    total++;
    if ({colSelect, keyCode, keyValid, keyHeld, overrun} !== 11'h780) begin
      fails++;
      $display("FAIL reset_outputs: got col=%b code=%h v=%b h=%b o=%b want 1111/0/0/0/0",
               colSelect, keyCode, keyValid, keyHeld, overrun);
    end
    reset = 1'b0;
    tick(1);
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    keys   = 16'h0;
    keyAck = 1'b0;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      exp = ~(4'b0001 << ((k % 16) / 4));
      total++;
      if (colSelect !== exp) begin
        fails++;
        $display("FAIL scan_pattern k=%0d: got %b want %b", k, colSelect, exp);
      end
      tick(1);
    end
    total++;
    if ({keyCode, keyValid, keyHeld, overrun} !== 7'h0) begin
      fails++;
      $display("FAIL idle_outputs: got code=%h v=%b h=%b o=%b want 0",
               keyCode, keyValid, keyHeld, overrun);
    end
  endtask

  task automatic test_press();
    align();
    keys = 16'h0200;
    tick(47);
    total++;
    if (keyValid !== 1'b0) begin
      fails++;
      $display("FAIL press_early: keyValid got %b want 0", keyValid);
    end
    tick(1);
    total++;
    if ({keyValid, keyHeld, keyCode} !== 6'b11_1001) begin
      fails++;
      $display("FAIL press_accept: got v=%b h=%b code=%h want 1/1/9",
               keyValid, keyHeld, keyCode);
    end
    tick(5);
    total++;
    if (keyValid !== 1'b1) begin
      fails++;
      $display("FAIL press_hold: keyValid got %b want 1", keyValid);
    end
    keyAck = 1'b1;
    tick(1);
    keyAck = 1'b0;
    total++;
    if ({keyValid, keyHeld} !== 2'b01) begin
      fails++;
      $display("FAIL press_ack: got v=%b h=%b want 0/1", keyValid, keyHeld);
    end
    align();
    keys = 16'h0;
    tick(48);
    total++;
    if (keyHeld !== 1'b0) begin
      fails++;
      $display("FAIL press_release: keyHeld got %b want 0", keyHeld);
    end
  endtask

  task automatic test_bounce();
    align();
    keys = 16'h0200;
    tick(32);
    keys = 16'h0;
    tick(64);
    total++;
    if ({keyValid, keyHeld, overrun} !== 3'b000) begin
      fails++;
      $display("FAIL bounce_reject: got v=%b h=%b o=%b want 0/0/0",
               keyValid, keyHeld, overrun);
    end
  endtask

  task automatic test_rebounce();
    align();
    keys = 16'h0200;
    tick(48);
    total++;
    if ({keyValid, keyCode} !== 5'b1_1001) begin
      fails++;
      $display("FAIL rebounce_accept: got v=%b code=%h want 1/9", keyValid, keyCode);
    end
    keyAck = 1'b1;
    tick(1);
    keyAck = 1'b0;
    align();
    keys = 16'h0;
    tick(16);
    keys = 16'h0200;
    tick(32);
    total++;
    if ({keyValid, keyHeld} !== 2'b01) begin
      fails++;
      $display("FAIL rebounce_repress: got v=%b h=%b want 0/1", keyValid, keyHeld);
    end
    keys = 16'h0;
    tick(32);
    total++;
    if (keyHeld !== 1'b1) begin
      fails++;
      $display("FAIL rebounce_rel2: keyHeld got %b want 1", keyHeld);
    end
    tick(16);
    total++;
    if (keyHeld !== 1'b0) begin
      fails++;
      $display("FAIL rebounce_rel3: keyHeld got %b want 0", keyHeld);
    end
  endtask

  task automatic test_overrun();
    align();
    keys = 16'h0240;
    tick(48);
    total++;
    if ({keyValid, keyCode, overrun} !== 6'b1_0110_0) begin
      fails++;
      $display("FAIL multi_lowest: got v=%b code=%h o=%b want 1/6/0",
               keyValid, keyCode, overrun);
    end
    keys = 16'h0;
    tick(48);
    keys = 16'h0010;
    tick(47);
    total++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_early: got %b want 0", overrun);
    end
    tick(1);
    total++;
    if ({keyValid, keyCode, overrun} !== 6'b1_0100_1) begin
      fails++;
      $display("FAIL overrun_set: got v=%b code=%h o=%b want 1/4/1",
               keyValid, keyCode, overrun);
    end
    keys = 16'h0;
    tick(48);
    total++;
    if ({overrun, keyHeld} !== 2'b10) begin
      fails++;
      $display("FAIL overrun_sticky: got o=%b h=%b want 1/0", overrun, keyHeld);
    end
  endtask

  task automatic test_midreset();
    align();
    keys = 16'h0020;
    tick(32);
    do_reset();
    tick(47);
    total++;
    if (keyValid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_early: keyValid got %b want 0", keyValid);
    end
    tick(1);
    total++;
    if ({keyValid, keyHeld, keyCode, overrun} !== 7'b11_0101_0) begin
      fails++;
      $display("FAIL midreset_accept: got v=%b h=%b code=%h o=%b want 1/1/5/0",
               keyValid, keyHeld, keyCode, overrun);
    end
  endtask

  initial begin
    total  = 0;
    fails  = 0;
    cyc    = 0;
    reset  = 1'b1;
    keyAck = 1'b0;
    keys   = 16'h0;
    test_reset();
    test_press();
    test_bounce();
    test_rebounce();
    test_overrun();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
    $finish;
  end

endmodule
